// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : ID-stage stall/flush controller. It handles load-use and
//               branch-in-ID hazards, flushes IF/ID on taken branches, runs the
//               HALT drain sequence and counts hazard stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_is_halt,
    input  logic             branch_taken,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_mem_read,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_flush,
    output logic             if_id_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int c_DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DCNT_W-1:0] c_DCNT_INIT = c_DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE  = c_DCNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_STALL  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_HALTED = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          r_rem;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0]    r_stall_count;

    logic [1:0]          w_state_nxt;
    logic [1:0]          w_rem_nxt;
    logic [c_DCNT_W-1:0] w_dcnt_nxt;

    logic                w_ex_match;
    logic                w_mem_match;
    logic                w_lu;
    logic                w_ba;
    logic                w_bl;
    logic                w_bm;
    logic [1:0]          w_need;
    logic                w_hazard_stall;

    // $0 is hard-wired zero, so a producer targeting it is never a dependency.
    function automatic logic f_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign w_ex_match  = f_match(id_ex_rd,  if_id_rs, if_id_rt, if_id_uses_rt);
    assign w_mem_match = f_match(ex_mem_rd, if_id_rs, if_id_rt, if_id_uses_rt);

    assign w_lu = id_ex_mem_read && w_ex_match;
    assign w_ba = id_is_branch && id_ex_reg_write && !id_ex_mem_read && w_ex_match;
    assign w_bl = id_is_branch && id_ex_mem_read && w_ex_match;
    assign w_bm = id_is_branch && ex_mem_mem_read && w_mem_match;

    assign w_need = w_bl ? 2'd2 : ((w_lu || w_ba || w_bm) ? 2'd1 : 2'd0);

    assign w_hazard_stall = ((r_state == c_ST_RUN) && (w_need != 2'd0))
                          || (r_state == c_ST_STALL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
            r_rem   <= 2'd0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            c_ST_RUN: begin
                if (w_need == 2'd2) begin
                    w_rem_nxt   = 2'd1;
                    w_state_nxt = c_ST_STALL;
                end else if ((w_need == 2'd0) && id_is_halt) begin
                    w_dcnt_nxt  = c_DCNT_INIT;
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_STALL: begin
                w_rem_nxt = r_rem - 2'd1;
                if (r_rem <= 2'd1) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_DRAIN: begin
                if (r_dcnt == '0) begin
                    w_state_nxt = c_ST_HALTED;
                end else begin
                    w_dcnt_nxt = r_dcnt - c_DCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_HALTED;
            end
        endcase
    end

    // Reset forces the pass-through pattern regardless of state.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_flush = 1'b0;
        if_id_flush = 1'b0;
        halted      = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_RUN: begin
                    if ((w_need != 2'd0) || id_is_halt) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (id_is_branch && branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                end
                c_ST_STALL, c_ST_DRAIN: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    halted      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_hazard_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Scenario bench for hazard_stall_unit, default and 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam logic [4:0] c_PASS  = 5'b11000;
    localparam logic [4:0] c_STALL = 5'b00100;
    localparam logic [4:0] c_FLUSH = 5'b11010;
    localparam logic [4:0] c_DRAIN = 5'b00100;
    localparam logic [4:0] c_HALT  = 5'b00101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic       if_id_uses_rt, id_is_branch, id_is_halt, branch_taken;
    logic       id_ex_reg_write, id_ex_mem_read, ex_mem_mem_read;

    logic        pc_write, if_id_write, id_ex_flush, if_id_flush, halted;
    logic [15:0] stall_count;
    logic        pc_write_s, if_id_write_s, id_ex_flush_s, if_id_flush_s, halted_s;
    logic [1:0]  stall_count_s;

    logic [4:0]  w_obs, w_obs_s;
    assign w_obs   = {pc_write, if_id_write, id_ex_flush, if_id_flush, halted};
    assign w_obs_s = {pc_write_s, if_id_write_s, id_ex_flush_s, if_id_flush_s, halted_s};

    hazard_stall_unit #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_is_branch(id_is_branch), .id_is_halt(id_is_halt), .branch_taken(branch_taken),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush),
        .if_id_flush(if_id_flush), .halted(halted), .stall_count(stall_count)
    );

    hazard_stall_unit #(.DRAIN_CYCLES(3), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_is_branch(id_is_branch), .id_is_halt(id_is_halt), .branch_taken(branch_taken),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
        .pc_write(pc_write_s), .if_id_write(if_id_write_s), .id_ex_flush(id_ex_flush_s),
        .if_id_flush(if_id_flush_s), .halted(halted_s), .stall_count(stall_count_s)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       br;
        logic       halt;
        logic       tk;
        logic [4:0] exrd;
        logic       exrw;
        logic       exmr;
        logic [4:0] memrd;
        logic       memmr;
        logic [4:0] eo;
        logic       hz;
    } step_t;

    typedef struct {
        logic [4:0] o;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    function automatic step_t mk(
        input logic rst, input logic [4:0] rs, input logic [4:0] rt,
        input logic urt, input logic br, input logic halt, input logic tk,
        input logic [4:0] exrd, input logic exrw, input logic exmr,
        input logic [4:0] memrd, input logic memmr,
        input logic [4:0] eo, input logic hz
    );
        step_t s;
        s.rst = rst; s.rs = rs; s.rt = rt; s.urt = urt; s.br = br;
        s.halt = halt; s.tk = tk; s.exrd = exrd; s.exrw = exrw; s.exmr = exmr;
        s.memrd = memrd; s.memmr = memmr; s.eo = eo; s.hz = hz;
        return s;
    endfunction

    // Drives one cycle of stimulus and queues what the outputs must show for it.
    task automatic apply(input step_t s);
        exp_t e;
        reset           = s.rst;
        if_id_rs        = s.rs;
        if_id_rt        = s.rt;
        if_id_uses_rt   = s.urt;
        id_is_branch    = s.br;
        id_is_halt      = s.halt;
        branch_taken    = s.tk;
        id_ex_rd        = s.exrd;
        id_ex_reg_write = s.exrw;
        id_ex_mem_read  = s.exmr;
        ex_mem_rd       = s.memrd;
        ex_mem_mem_read = s.memmr;
        e.o   = s.eo;
        e.cnt = exp_cnt;
        sb.push_back(e);
        if (s.rst)      exp_cnt = 0;
        else if (s.hz)  exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_reset();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(1, 2,0,0,0,0,0, 2,1,1, 0,0, c_PASS,  0));
        t.push_back(mk(1, 0,0,0,0,1,0, 0,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (w_obs !== e.o) begin n_fail++; $display("FAIL reset[%0d] outputs got %b expected %b", i, w_obs, e.o); end
            n_chk++; if (w_obs_s !== e.o) begin n_fail++; $display("FAIL reset[%0d] outputs_s got %b expected %b", i, w_obs_s, e.o); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL reset[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(0, 2,7,1,0,0,0, 2,1,1, 0,0, c_STALL, 1));
        t.push_back(mk(0, 2,7,1,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 1,9,1,0,0,0, 9,1,1, 0,0, c_STALL, 1));
        t.push_back(mk(0, 1,9,1,0,0,0, 0,0,0, 9,1, c_PASS,  0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (w_obs !== e.o) begin n_fail++; $display("FAIL load_use[%0d] outputs got %b expected %b", i, w_obs, e.o); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL load_use[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_load();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(0, 3,0,0,1,0,0, 3,1,1, 0,0, c_STALL, 1));
        t.push_back(mk(0, 3,0,0,1,1,1, 0,0,0, 3,1, c_STALL, 1));
        t.push_back(mk(0, 3,0,0,1,0,0, 0,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 4,6,1,1,0,0, 0,0,0, 6,1, c_STALL, 1));
        t.push_back(mk(0, 4,6,1,1,0,1, 0,0,0, 0,0, c_FLUSH, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (w_obs !== e.o) begin n_fail++; $display("FAIL branch_load[%0d] outputs got %b expected %b", i, w_obs, e.o); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL branch_load[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_alu();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1,5,1,1,0,0, 5,1,0, 0,0, c_STALL, 1));
        t.push_back(mk(0, 1,5,1,1,0,1, 0,0,0, 0,0, c_FLUSH, 0));
        t.push_back(mk(0, 5,1,0,1,0,0, 5,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 5,1,0,0,0,0, 5,1,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 0,0,1,1,0,1, 0,1,0, 0,0, c_FLUSH, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (w_obs !== e.o) begin n_fail++; $display("FAIL branch_alu[%0d] outputs got %b expected %b", i, w_obs, e.o); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL branch_alu[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_hazard_priority();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(0, 0,0,1,0,0,0, 0,1,1, 0,0, c_PASS,  0));
        t.push_back(mk(0, 1,4,0,0,0,0, 4,1,1, 0,0, c_PASS,  0));
        t.push_back(mk(0, 1,4,0,1,0,0, 4,1,1, 4,1, c_PASS,  0));
        t.push_back(mk(0, 8,0,0,1,0,1, 8,1,1, 0,0, c_STALL, 1));
        t.push_back(mk(0, 8,0,0,1,0,1, 0,0,0, 8,1, c_STALL, 1));
        t.push_back(mk(0, 8,0,0,1,0,1, 0,0,0, 0,0, c_FLUSH, 0));
        t.push_back(mk(0, 2,0,0,0,1,0, 2,1,1, 0,0, c_STALL, 1));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (w_obs !== e.o) begin n_fail++; $display("FAIL no_hazard[%0d] outputs got %b expected %b", i, w_obs, e.o); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL no_hazard[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        step_t t[$];
        exp_t  e;
        t.push_back(mk(0, 2,0,0,0,1,0, 0,0,0, 0,0, c_DRAIN, 0));
        t.push_back(mk(0, 2,0,0,0,1,0, 2,1,1, 0,0, c_DRAIN, 0));
        t.push_back(mk(0, 3,0,0,1,0,1, 3,1,1, 0,0, c_DRAIN, 0));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_DRAIN, 0));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_HALT,  0));
        t.push_back(mk(0, 2,0,0,1,0,1, 2,1,1, 0,0, c_HALT,  0));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_HALT,  0));
        t.push_back(mk(1, 0,0,0,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++; if (w_obs !== e.o) begin n_fail++; $display("FAIL halt[%0d] outputs got %b expected %b", i, w_obs, e.o); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL halt[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate_reset_in_stall();
        step_t t[$];
        exp_t  e;
        logic [1:0] w_sat;
        for (int k = 0; k < 5; k++) begin
            t.push_back(mk(0, 6,0,0,0,0,0, 6,1,1, 0,0, c_STALL, 1));
        end
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 3,0,0,1,0,0, 3,1,1, 0,0, c_STALL, 1));
        t.push_back(mk(1, 3,0,0,1,0,0, 0,0,0, 3,1, c_PASS,  0));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        t.push_back(mk(0, 6,0,0,0,0,0, 6,1,1, 0,0, c_STALL, 1));
        t.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0, c_PASS,  0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            w_sat = (e.cnt > 3) ? 2'd3 : 2'(e.cnt);
            n_chk++; if (w_obs_s !== e.o) begin n_fail++; $display("FAIL saturate[%0d] outputs_s got %b expected %b", i, w_obs_s, e.o); end
            n_chk++; if (stall_count_s !== w_sat) begin n_fail++; $display("FAIL saturate[%0d] stall_count_s got %0d expected %0d", i, stall_count_s, w_sat); end
            n_chk++; if (stall_count !== 16'(e.cnt)) begin n_fail++; $display("FAIL saturate[%0d] stall_count got %0d expected %0d", i, stall_count, e.cnt); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset           = 1'b1;
        if_id_rs        = '0;
        if_id_rt        = '0;
        if_id_uses_rt   = 1'b0;
        id_is_branch    = 1'b0;
        id_is_halt      = 1'b0;
        branch_taken    = 1'b0;
        id_ex_rd        = '0;
        id_ex_reg_write = 1'b0;
        id_ex_mem_read  = 1'b0;
        ex_mem_rd       = '0;
        ex_mem_mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_no_hazard_priority();
        test_halt();
        test_saturate_reset_in_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
